fc_output_argmax: RTL and testbench
===================================

// Module: fc_output_argmax
// PURPOSE
//   Final classifier stage, directly downstream of the 60->48 hidden FC layer.
//   Computes N_OUT class scores from the N_IN hidden activations in temp RAM.
//   score[k] = bias[k] + sum_i act[i]*W[k][i]; no ReLU is applied.
//   Tracks the running maximum score and reports the winning digit index and its score.
// PARAMETERS
//   N_IN        48  activations per class (hidden layer width)
//   N_OUT       10  number of classes (digits 0-9)
//   FRAC_BITS   16  fractional bits of the Q16.16 fixed-point format
//   WEIGHT_BASE 0   base word address of the class-major weight block
//   BIAS_BASE   0   base word address of the bias block
// PORTS
//   Clk          in   1   clock
//   Reset        in   1   synchronous, active-high reset
//   start        in   1   begin classification; sampled only in IDLE
//   act_data     in   32  signed activation; RAM output
//   weight       in   32  signed weight; RAM output
//   bias         in   32  signed bias; RAM output
//   act_addr     out  14  activation RAM address = step
//   weight_addr  out  14  WEIGHT_BASE + neuron*N_IN + step
//   bias_addr    out  10  BIAS_BASE + neuron
//   digit        out  4   winning class index; registered
//   max_score    out  32  winning class score; registered, signed
//   ready        out  1   high for exactly 1 cycle while in DONE
//   busy         out  1   high whenever state != IDLE
// BEHAVIOUR
//   - All addresses are combinational from the counters.
//   - All RAMs have 1-cycle read latency: an address presented in cycle n gives valid data in cycle n+1.
//   - Reset: state=IDLE, neuron=0, step=0, acc=0, best=32'h8000_0000, best_idx=0.
//   - Reset outputs: digit=0, max_score=0, ready=0, busy=0.
//   - Reset mid-operation aborts the run with no partial result; the next start restarts from class 0.
//   - IDLE: on start, set neuron=0, step=0, best=32'h8000_0000, best_idx=0; go to CHECK_NEURON.
//   - CHECK_NEURON:
//       - acc<=0.
//       - If neuron==N_OUT: digit<=best_idx, max_score<=best; go to DONE.
//       - Otherwise go to LOAD_BIAS.
//   - LOAD_BIAS: bias_reg<=bias (the address was stable during the previous cycle); go to CHECK_STEP.
//   - CHECK_STEP:
//       - If step==N_IN: acc<=acc+bias_reg, step<=0; go to COMPARE.
//       - Otherwise go to LOAD.
//   - LOAD: latch act_data and weight; step<=step+1; go to ACCUMULATE.
//   - ACCUMULATE: acc<=acc+prod; go to CHECK_STEP.
//   - COMPARE:
//       - If acc > best (signed, strict): best<=acc, best_idx<=neuron.
//       - neuron<=neuron+1; go to CHECK_NEURON.
//   - DONE: ready=1; go to IDLE. A start seen during DONE is ignored.
//   - start is ignored whenever busy=1.
//   - digit and max_score hold their values until the next completed run.
//   - Arithmetic:
//       - prod = (64-bit signed act*weight) >>> FRAC_BITS, keeping bits [31:0] (rounds toward -inf).
//       - acc and bias adds are 32-bit two's complement, wrap on overflow, no saturation.
//   - Ties resolve to the lowest class index because the compare is strict.
//     A class equal to 32'h8000_0000 never beats the initial best; index 0 is kept.
//   - Per class: 3*N_IN+4 cycles.
//   - ready rises N_OUT*(3*N_IN+4)+1 clock edges after the edge that samples start.
//     With defaults this is 1481 cycles.
// TESTING
//   1. W=0, bias[k]=k*0x10000 except bias[7]=0x00200000 -> digit=7, max_score=0x00200000, one ready pulse.
//   2. W=0, all bias=0x00010000 (tie) -> digit=0, max_score=0x00010000.
//   3. act[i]=0x00010000, W[3][*]=0x00008000, other W=0, bias=0
//      -> class 3 score 0x00180000, digit=3, max_score=0x00180000.
//   4. W=0, bias[k]=-(k+1)*0x10000 (all negative) -> digit=0, max_score=0xFFFF0000.
//   5. Pulse start; pulse start again at cycle 100
//      -> ready exactly at cycle 1481, high 1 cycle, second start ignored;
//      -> weight_addr sequence 0..479, bias_addr sequence 0..9.
//   6. Assert Reset at cycle 500 -> next cycle busy=0, ready=0, digit=0, max_score=0;
//      then rerun test 1 -> digit=7.

Source files
------------

// File: rtl/fc_output_argmax.sv
// Final classifier stage: scores N_OUT classes from N_IN hidden activations
// (Q16.16) and reports the arg-max class index together with its score.
module fc_output_argmax #(
  parameter int N_IN        = 48,
  parameter int N_OUT       = 10,
  parameter int FRAC_BITS   = 16,
  parameter int WEIGHT_BASE = 0,
  parameter int BIAS_BASE   = 0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  input  logic [31:0] act_data,
  input  logic [31:0] weight,
  input  logic [31:0] bias,
  output logic [13:0] act_addr,
  output logic [13:0] weight_addr,
  output logic [9:0]  bias_addr,
  output logic [3:0]  digit,
  output logic [31:0] max_score,
  output logic        ready,
  output logic        busy,
  output logic [2:0]  dbg_state_o
);

  localparam int SW = $clog2(N_IN + 1);
  localparam int NW = $clog2(N_OUT + 1);
  localparam logic [SW-1:0] N_IN_C  = SW'(N_IN);
  localparam logic [NW-1:0] N_OUT_C = NW'(N_OUT);
  localparam logic [31:0]   BEST_INIT = 32'h8000_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK_NEURON,
    S_LOAD_BIAS,
    S_CHECK_STEP,
    S_LOAD,
    S_ACCUMULATE,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [NW-1:0]      neuron_q, neuron_d;
  logic [SW-1:0]      step_q, step_d;
  logic signed [31:0] acc_q, acc_d;
  logic signed [31:0] best_q, best_d;
  logic [3:0]         best_idx_q, best_idx_d;
  logic signed [31:0] bias_q, bias_d;
  logic signed [31:0] act_q, act_d;
  logic signed [31:0] w_q, w_d;
  logic [3:0]         digit_q, digit_d;
  logic [31:0]        max_q, max_d;

  logic signed [63:0] act_ext, w_ext, prod_full, prod_shift;
  logic signed [31:0] prod;

  // Full 64-bit signed product, then arithmetic shift back to Q16.16
  // (floor rounding); the upper bits are dropped, so large products wrap.
  assign act_ext    = {{32{act_q[31]}}, act_q};
  assign w_ext      = {{32{w_q[31]}}, w_q};
  assign prod_full  = act_ext * w_ext;
  assign prod_shift = prod_full >>> FRAC_BITS;
  assign prod       = prod_shift[31:0];

  // RAM addresses are purely combinational from the counters; the RAMs
  // return data one cycle after the address is presented.
  assign act_addr    = 14'(step_q);
  assign weight_addr = 14'(WEIGHT_BASE) + 14'(neuron_q) * 14'(N_IN) + 14'(step_q);
  assign bias_addr   = 10'(BIAS_BASE) + 10'(neuron_q);

  // Handshake: start is a request honoured only while busy is low; ready is
  // a single-cycle completion strobe, after which digit/max_score are valid
  // and stay stable until the next completed run.
  assign ready       = (state_q == S_DONE);
  assign busy        = (state_q != S_IDLE);
  assign digit       = digit_q;
  assign max_score   = max_q;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d    = state_q;
    neuron_d   = neuron_q;
    step_d     = step_q;
    acc_d      = acc_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    bias_d     = bias_q;
    act_d      = act_q;
    w_d        = w_q;
    digit_d    = digit_q;
    max_d      = max_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          neuron_d   = '0;
          step_d     = '0;
          best_d     = BEST_INIT;
          best_idx_d = '0;
          state_d    = S_CHECK_NEURON;
        end
      end
      S_CHECK_NEURON: begin
        acc_d = '0;
        if (neuron_q == N_OUT_C) begin
          digit_d = best_idx_q;
          max_d   = best_q;
          state_d = S_DONE;
        end else begin
          state_d = S_LOAD_BIAS;
        end
      end
      S_LOAD_BIAS: begin
        bias_d  = bias;
        state_d = S_CHECK_STEP;
      end
      S_CHECK_STEP: begin
        if (step_q == N_IN_C) begin
          acc_d   = acc_q + bias_q;
          step_d  = '0;
          state_d = S_COMPARE;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        act_d   = act_data;
        w_d     = weight;
        step_d  = step_q + SW'(1);
        state_d = S_ACCUMULATE;
      end
      S_ACCUMULATE: begin
        acc_d   = acc_q + prod;
        state_d = S_CHECK_STEP;
      end
      S_COMPARE: begin
        // Strict compare: ties keep the lower class index.
        if (acc_q > best_q) begin
          best_d     = acc_q;
          best_idx_d = 4'(neuron_q);
        end
        neuron_d = neuron_q + NW'(1);
        state_d  = S_CHECK_NEURON;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      neuron_q   <= '0;
      step_q     <= '0;
      acc_q      <= '0;
      best_q     <= BEST_INIT;
      best_idx_q <= '0;
      bias_q     <= '0;
      act_q      <= '0;
      w_q        <= '0;
      digit_q    <= '0;
      max_q      <= '0;
    end else begin
      state_q    <= state_d;
      neuron_q   <= neuron_d;
      step_q     <= step_d;
      acc_q      <= acc_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      bias_q     <= bias_d;
      act_q      <= act_d;
      w_q        <= w_d;
      digit_q    <= digit_d;
      max_q      <= max_d;
    end
  end

endmodule

// File: tb/tb_fc_output_argmax.sv
// Bench for fc_output_argmax: behavioural RAMs, arithmetic reference model,
// directed scenarios plus randomized runs.
module tb_fc_output_argmax;

  localparam int N_IN  = 48;
  localparam int N_OUT = 10;
  localparam int N_W   = N_IN * N_OUT;
  localparam int LAT   = N_OUT * (3 * N_IN + 4) + 1;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] act_data, weight, bias;
  logic [13:0] act_addr, weight_addr;
  logic [9:0]  bias_addr;
  logic [3:0]  digit;
  logic [31:0] max_score;
  logic        ready, busy;
  logic [2:0]  dbg_state;

  int act_mem[N_IN];
  int w_mem[N_W];
  int b_mem[N_OUT];

  int n_checks = 0;
  int n_fails  = 0;
  logic [31:0] exp_q[$];

  bit track = 1'b0;
  bit w_seen[N_W];
  bit b_seen[N_OUT];
  int w_order[$];
  int b_order[$];

  fc_output_argmax dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .start      (start),
    .act_data   (act_data),
    .weight     (weight),
    .bias       (bias),
    .act_addr   (act_addr),
    .weight_addr(weight_addr),
    .bias_addr  (bias_addr),
    .digit      (digit),
    .max_score  (max_score),
    .ready      (ready),
    .busy       (busy),
    .dbg_state_o(dbg_state)
  );

  // Clock and synchronous single-cycle-latency RAMs.
  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    act_data <= (act_addr < 14'(N_IN)) ? act_mem[act_addr] : 32'd0;
    weight   <= (weight_addr < 14'(N_W)) ? w_mem[weight_addr] : 32'd0;
    bias     <= (bias_addr < 10'(N_OUT)) ? b_mem[bias_addr] : 32'd0;
  end

  // First-appearance order of addresses presented while busy.
  always @(negedge Clk) begin
    if (track && busy) begin
      if (weight_addr < 14'(N_W) && !w_seen[weight_addr]) begin
        w_seen[weight_addr] = 1'b1;
        w_order.push_back(int'(weight_addr));
      end
      if (bias_addr < 10'(N_OUT) && !b_seen[bias_addr]) begin
        b_seen[bias_addr] = 1'b1;
        b_order.push_back(int'(bias_addr));
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: score = sum(floor(act*w / 2^16)) + bias, 32-bit wrap; strict arg-max.
  task automatic ref_model(output int exp_idx, output int exp_score);
    int best;
    int acc;
    longint p;
    best    = 32'h8000_0000;
    exp_idx = 0;
    for (int k = 0; k < N_OUT; k++) begin
      acc = 0;
      for (int i = 0; i < N_IN; i++) begin
        p   = longint'(act_mem[i]) * longint'(w_mem[k * N_IN + i]);
        acc = acc + int'(p >>> 16);
      end
      acc = acc + b_mem[k];
      if (acc > best) begin
        best    = acc;
        exp_idx = k;
      end
    end
    exp_score = best;
  endtask

  task automatic clear_mems();
    for (int i = 0; i < N_IN; i++) act_mem[i] = 0;
    for (int i = 0; i < N_W; i++) w_mem[i] = 0;
    for (int k = 0; k < N_OUT; k++) b_mem[k] = 0;
  endtask

  task automatic load_test1();
    clear_mems();
    for (int i = 0; i < N_IN; i++) act_mem[i] = int'($urandom);
    for (int k = 0; k < N_OUT; k++) b_mem[k] = k * 32'h10000;
    b_mem[7] = 32'h0020_0000;
  endtask

  // One classification run: start pulse, bounded wait for ready, result and
  // strobe-width checks. A start is also offered during DONE to see it ignored.
  task automatic run_and_check(input string tag, input int restart_at,
                               input logic [31:0] exp_digit, input logic [31:0] exp_score);
    int  cyc;
    bit  seen;
    logic [31:0] e_dig, e_sc;
    exp_q.push_back(exp_digit);
    exp_q.push_back(exp_score);
    @(negedge Clk); start = 1'b1;
    @(negedge Clk); start = 1'b0;
    check({tag, "_busy_start"}, 32'(busy), 32'd1);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < LAT + 50) begin
      @(negedge Clk);
      cyc++;
      start = (cyc == restart_at);
      if (ready) begin
        seen  = 1'b1;
        start = 1'b1;
      end
    end
    e_dig = exp_q.pop_front();
    e_sc  = exp_q.pop_front();
    check({tag, "_latency"}, 32'(cyc), 32'(LAT));
    check({tag, "_digit"}, 32'(digit), e_dig);
    check({tag, "_max_score"}, max_score, e_sc);
    @(negedge Clk); start = 1'b0;
    check({tag, "_ready_width"}, 32'(ready), 32'd0);
    check({tag, "_idle_after"}, 32'(busy), 32'd0);
    @(negedge Clk);
    check({tag, "_hold_digit"}, 32'(digit), e_dig);
  endtask

  initial begin
    int e_idx, e_sc, bad, v;

    clear_mems();
    repeat (3) @(negedge Clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ready", 32'(ready), 32'd0);
    check("reset_digit", 32'(digit), 32'd0);
    check("reset_max", max_score, 32'd0);
    Reset = 1'b0;

    // 1: winner decided by bias alone.
    load_test1();
    run_and_check("t1", -1, 32'd7, 32'h0020_0000);

    // 2: all classes tie -> lowest index.
    clear_mems();
    for (int k = 0; k < N_OUT; k++) b_mem[k] = 32'h0001_0000;
    run_and_check("t2", -1, 32'd0, 32'h0001_0000);

    // 3: only class 3 has weights.
    clear_mems();
    for (int i = 0; i < N_IN; i++) act_mem[i] = 32'h0001_0000;
    for (int i = 0; i < N_IN; i++) w_mem[3 * N_IN + i] = 32'h0000_8000;
    run_and_check("t3", -1, 32'd3, 32'h0018_0000);

    // 4: all scores negative.
    clear_mems();
    for (int k = 0; k < N_OUT; k++) b_mem[k] = -(k + 1) * 32'h10000;
    run_and_check("t4", -1, 32'd0, 32'hFFFF_0000);

    // 5: second start mid-run is ignored; address coverage order.
    load_test1();
    track = 1'b1;
    run_and_check("t5", 100, 32'd7, 32'h0020_0000);
    track = 1'b0;
    bad = 0;
    foreach (w_order[i]) if (w_order[i] != i) bad++;
    check("t5_waddr_count", 32'(w_order.size()), 32'(N_W));
    check("t5_waddr_order", 32'(bad), 32'd0);
    bad = 0;
    foreach (b_order[i]) if (b_order[i] != i) bad++;
    check("t5_baddr_count", 32'(b_order.size()), 32'(N_OUT));
    check("t5_baddr_order", 32'(bad), 32'd0);

    // 6: reset mid-run clears everything; the next run starts cleanly.
    clear_mems();
    for (int i = 0; i < N_IN; i++) act_mem[i] = int'($urandom);
    for (int i = 0; i < N_W; i++) w_mem[i] = int'($urandom);
    @(negedge Clk); start = 1'b1;
    @(negedge Clk); start = 1'b0;
    repeat (499) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_ready", 32'(ready), 32'd0);
    check("t6_digit", 32'(digit), 32'd0);
    check("t6_max", max_score, 32'd0);
    Reset = 1'b0;
    load_test1();
    run_and_check("t6_rerun", -1, 32'd7, 32'h0020_0000);

    // Randomized: small magnitudes, then full-range values that wrap.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N_IN; i++) act_mem[i] = int'($urandom_range(0, 32'h3FFFF)) - 32'h20000;
      for (int i = 0; i < N_W; i++) w_mem[i] = int'($urandom_range(0, 32'h3FFFF)) - 32'h20000;
      for (int k = 0; k < N_OUT; k++) b_mem[k] = int'($urandom_range(0, 32'hFFFFF)) - 32'h80000;
      ref_model(e_idx, e_sc);
      run_and_check($sformatf("rnd_small%0d", r), -1, 32'(e_idx), e_sc);
    end
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N_IN; i++) act_mem[i] = int'($urandom);
      for (int i = 0; i < N_W; i++) w_mem[i] = int'($urandom);
      for (int k = 0; k < N_OUT; k++) b_mem[k] = int'($urandom);
      ref_model(e_idx, e_sc);
      run_and_check($sformatf("rnd_wide%0d", r), -1, 32'(e_idx), e_sc);
    end

    // Random ties between two bias levels.
    clear_mems();
    v = int'($urandom_range(1, 1000)) * 32'h100;
    for (int k = 0; k < N_OUT; k++) b_mem[k] = ($urandom_range(0, 1) == 1) ? v : v - 1;
    ref_model(e_idx, e_sc);
    run_and_check("rnd_tie", -1, 32'(e_idx), e_sc);

    // Every class equals the initial best: it never wins, index 0 kept.
    clear_mems();
    for (int k = 0; k < N_OUT; k++) b_mem[k] = 32'h8000_0000;
    run_and_check("min_all", -1, 32'd0, 32'h8000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
